// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch-stage controller: FSM state encodings,
// program-counter control codes and the wait-counter width.
package fetch_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ISSUE = 3'd3,
        ST_SEL   = 3'd4,
        ST_LOAD  = 3'd5,
        ST_HALT  = 3'd6
    } fetch_state_e;

    localparam logic [1:0] PC_HOLD  = 2'b00;
    localparam logic [1:0] PC_INC   = 2'b01;
    localparam logic [1:0] PC_LOAD  = 2'b10;
    localparam logic [1:0] PC_CLEAR = 2'b11;

    // Memory latency is at most 15, so a 4-bit down-counter covers it.
    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/fetch_wait_counter.sv
// Loadable down-counter used to pace instruction-memory reads.
// Stops at zero and raises done while the count is zero.
module fetch_wait_counter
    import fetch_ctrl_pkg::*;
#(
    parameter int CNT_W = WAIT_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Load has priority over decrement; decrement never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign done  = (count_q == '0);

endmodule

// File: rtl/fetch_controller.sv
// Fetch-stage sequencing FSM: paces memory reads, holds the fetched
// instruction until decode accepts it, and applies jump / jump-register /
// taken-branch redirects in two steps (register target, then load PC).
// Optional build macro FETCH_STALL_CNT_EN adds a saturating 16-bit count of
// ISSUE cycles in which decode applied backpressure.
module fetch_controller
    import fetch_ctrl_pkg::*;
#(
    parameter int flag    = 2,
    parameter int MEM_LAT = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            dec_ready,
    input  logic            jump,
    input  logic            jr,
    input  logic            branch,
    input  logic            halt,
    input  logic            resume,
    output logic [flag-1:0] flagPC,
    output logic            flagJR,
    output logic            inst_valid,
    output logic [2:0]      fetch_state
`ifdef FETCH_STALL_CNT_EN
   ,output logic [15:0]     stall_count
`endif
);

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(MEM_LAT - 1);

    fetch_state_e state_q;
    fetch_state_e state_d;
    logic         jr_q;
    logic         jr_d;

    logic                  cnt_load;
    logic                  cnt_dec;
    logic [WAIT_CNT_W-1:0] wait_count;
    logic                  wait_done;
    logic                  wait_last;
    logic                  redirect;
    logic [1:0]            pc_code;

    fetch_wait_counter #(
        .CNT_W (WAIT_CNT_W)
    ) u_wait_counter (
        .clock    (clock),
        .reset    (reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (WAIT_LOAD),
        .count    (wait_count),
        .done     (wait_done)
    );

    assign redirect = jr | jump | branch;
    // The decrement taking the count from 1 to 0 is the last WAIT cycle.
    assign wait_last = wait_done || (wait_count == WAIT_CNT_W'(1));

    // Next-state logic; redirect/halt inputs matter only on the ISSUE handshake.
    always_comb begin
        state_d  = state_q;
        jr_d     = jr_q;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = ST_FETCH;
            ST_FETCH: begin
                cnt_load = 1'b1;
                state_d  = (MEM_LAT > 1) ? ST_WAIT : ST_ISSUE;
            end
            ST_WAIT: begin
                cnt_dec = 1'b1;
                if (wait_last) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dec_ready) begin
                    if (halt) begin
                        state_d = ST_HALT;
                    end else if (redirect) begin
                        state_d = ST_SEL;
                        jr_d    = jr;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end
            end
            ST_SEL:   state_d = ST_LOAD;
            ST_LOAD:  state_d = ST_FETCH;
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_FETCH;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // State and latched JR flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            jr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            jr_q    <= jr_d;
        end
    end

    // Output decode from state; only ISSUE looks at the live handshake inputs.
    always_comb begin
        pc_code    = PC_HOLD;
        flagJR     = 1'b0;
        inst_valid = 1'b0;
        case (state_q)
            ST_IDLE:  pc_code = PC_CLEAR;
            ST_ISSUE: begin
                inst_valid = 1'b1;
                if (dec_ready && (halt || !redirect)) begin
                    pc_code = PC_INC;
                end
            end
            ST_SEL:   flagJR = jr_q;
            ST_LOAD: begin
                flagJR  = jr_q;
                pc_code = PC_LOAD;
            end
            default:  pc_code = PC_HOLD;
        endcase
    end

    assign flagPC      = flag'(pc_code);
    assign fetch_state = state_q;

`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    // Count ISSUE cycles stalled by decode, saturating at all-ones.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_ISSUE) && !dec_ready && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    // Stall counter register, cleared by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_q <= 16'd0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_fetch_controller.sv
// Bench for fetch_controller: two instances (memory latency 1 and 3) with
// independent inputs, a phase-based reference model checked every cycle,
// and directed scenarios with literal expectations.
module tb_fetch_controller;

    localparam int LAT0 = 1;
    localparam int LAT1 = 3;

    localparam int P_BOOT    = 0;
    localparam int P_READ    = 1;
    localparam int P_PRESENT = 2;
    localparam int P_REDIR   = 3;
    localparam int P_HALTED  = 4;

    logic clock;
    logic reset;
    logic dr  [2];
    logic jp  [2];
    logic jrr [2];
    logic br  [2];
    logic hl  [2];
    logic rs  [2];

    logic [1:0] fpc [2];
    logic       fjr [2];
    logic       iv  [2];
    logic [2:0] fs  [2];
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] sc [2];
`endif

    int n_checks = 0;
    int n_pass   = 0;

    int m_phase [2];
    int m_age   [2];
    int m_step  [2];
    bit m_rjr   [2];
    int m_stall [2];

    int exp_pc1 [5] = '{3, 0, 1, 0, 1};
    int exp_v1  [5] = '{0, 0, 1, 0, 1};
    int exp_st3 [5] = '{0, 1, 2, 2, 3};

    fetch_controller #(.flag(2), .MEM_LAT(LAT0)) u_lat1 (
        .clock(clock), .reset(reset), .dec_ready(dr[0]), .jump(jp[0]), .jr(jrr[0]),
        .branch(br[0]), .halt(hl[0]), .resume(rs[0]), .flagPC(fpc[0]), .flagJR(fjr[0]),
        .inst_valid(iv[0]), .fetch_state(fs[0])
`ifdef FETCH_STALL_CNT_EN
       ,.stall_count(sc[0])
`endif
    );

    fetch_controller #(.flag(2), .MEM_LAT(LAT1)) u_lat3 (
        .clock(clock), .reset(reset), .dec_ready(dr[1]), .jump(jp[1]), .jr(jrr[1]),
        .branch(br[1]), .halt(hl[1]), .resume(rs[1]), .flagPC(fpc[1]), .flagJR(fjr[1]),
        .inst_valid(iv[1]), .fetch_state(fs[1])
`ifdef FETCH_STALL_CNT_EN
       ,.stall_count(sc[1])
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic int lat_of(input int i);
        return (i == 0) ? LAT0 : LAT1;
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_state(input int i, input int s);
        int k = 0;
        while (int'(fs[i]) != s && k < 40) begin
            step();
            k++;
        end
        chk($sformatf("dut%0d.wait_for_state", i), int'(fs[i]), s);
    endtask

    // Reference model: a program is booting, reading memory for lat cycles,
    // presenting an instruction, redirecting (two steps) or halted.
    always @(posedge clock or posedge reset) begin
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_phase[i] <= P_BOOT;
                m_age[i]   <= 0;
                m_step[i]  <= 0;
                m_rjr[i]   <= 1'b0;
                m_stall[i] <= 0;
            end else begin
                case (m_phase[i])
                    P_BOOT: begin
                        m_phase[i] <= P_READ;
                        m_age[i]   <= 0;
                    end
                    P_READ: begin
                        if (m_age[i] + 1 >= lat_of(i)) m_phase[i] <= P_PRESENT;
                        else m_age[i] <= m_age[i] + 1;
                    end
                    P_PRESENT: begin
                        if (!dr[i] && m_stall[i] < 65535) m_stall[i] <= m_stall[i] + 1;
                        if (dr[i]) begin
                            if (hl[i]) begin
                                m_phase[i] <= P_HALTED;
                            end else if (jrr[i] || jp[i] || br[i]) begin
                                m_phase[i] <= P_REDIR;
                                m_step[i]  <= 0;
                                m_rjr[i]   <= jrr[i];
                            end else begin
                                m_phase[i] <= P_READ;
                                m_age[i]   <= 0;
                            end
                        end
                    end
                    P_REDIR: begin
                        if (m_step[i] == 0) begin
                            m_step[i] <= 1;
                        end else begin
                            m_phase[i] <= P_READ;
                            m_age[i]   <= 0;
                        end
                    end
                    P_HALTED: begin
                        if (rs[i]) begin
                            m_phase[i] <= P_READ;
                            m_age[i]   <= 0;
                        end
                    end
                    default: m_phase[i] <= P_BOOT;
                endcase
            end
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            int e_pc, e_jr, e_v, e_st;
            e_pc = 0; e_jr = 0; e_v = 0; e_st = 0;
            case (m_phase[i])
                P_BOOT: begin e_pc = 3; e_st = 0; end
                P_READ: e_st = (m_age[i] == 0) ? 1 : 2;
                P_PRESENT: begin
                    e_st = 3;
                    e_v  = 1;
                    if (dr[i]) e_pc = (hl[i] || !(jrr[i] || jp[i] || br[i])) ? 1 : 0;
                end
                P_REDIR: begin
                    e_st = (m_step[i] == 0) ? 4 : 5;
                    e_pc = (m_step[i] == 0) ? 0 : 2;
                    e_jr = int'(m_rjr[i]);
                end
                P_HALTED: e_st = 6;
                default: e_st = 7;
            endcase
            chk($sformatf("dut%0d.flagPC", i), int'(fpc[i]), e_pc);
            chk($sformatf("dut%0d.flagJR", i), int'(fjr[i]), e_jr);
            chk($sformatf("dut%0d.inst_valid", i), int'(iv[i]), e_v);
            chk($sformatf("dut%0d.fetch_state", i), int'(fs[i]), e_st);
`ifdef FETCH_STALL_CNT_EN
            chk($sformatf("dut%0d.stall_count", i), int'(sc[i]), m_stall[i]);
`endif
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dr[i] = 1'b1; jp[i] = 1'b0; jrr[i] = 1'b0;
            br[i] = 1'b0; hl[i] = 1'b0; rs[i] = 1'b0;
        end
        repeat (2) step();

        // Reset values.
        @(negedge clock);
        chk("rst.flagPC", int'(fpc[0]), 3);
        chk("rst.flagJR", int'(fjr[0]), 0);
        chk("rst.inst_valid", int'(iv[0]), 0);
        chk("rst.fetch_state", int'(fs[1]), 0);
`ifdef FETCH_STALL_CNT_EN
        chk("rst.stall_count", int'(sc[1]), 0);
`endif
        step();
        reset = 1'b0;

        // Start-up: MEM_LAT=1 flagPC/inst_valid pattern, MEM_LAT=3 state walk.
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("seq1.flagPC[%0d]", k), int'(fpc[0]), exp_pc1[k]);
            chk($sformatf("seq1.inst_valid[%0d]", k), int'(iv[0]), exp_v1[k]);
            chk($sformatf("seq3.fetch_state[%0d]", k), int'(fs[1]), exp_st3[k]);
        end
        step();

        // jr together with jump on the handshake.
        wait_state(1, 3);
        jrr[1] = 1'b1; jp[1] = 1'b1;
        @(negedge clock);
        chk("jrj.issue_flagPC", int'(fpc[1]), 0);
        chk("jrj.issue_valid", int'(iv[1]), 1);
        step();
        jrr[1] = 1'b0; jp[1] = 1'b0;
        @(negedge clock);
        chk("jrj.sel_state", int'(fs[1]), 4);
        chk("jrj.sel_flagJR", int'(fjr[1]), 1);
        step();
        @(negedge clock);
        chk("jrj.load_state", int'(fs[1]), 5);
        chk("jrj.load_flagPC", int'(fpc[1]), 2);
        chk("jrj.load_flagJR", int'(fjr[1]), 1);
        step();
        @(negedge clock);
        chk("jrj.fetch_state", int'(fs[1]), 1);
        chk("jrj.fetch_flagJR", int'(fjr[1]), 0);
        step();

        // Five cycles of decode backpressure.
        dr[1] = 1'b0;
        wait_state(1, 3);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            chk($sformatf("stall.flagPC[%0d]", k), int'(fpc[1]), 0);
            chk($sformatf("stall.inst_valid[%0d]", k), int'(iv[1]), 1);
            step();
        end
        dr[1] = 1'b1;
        @(negedge clock);
        chk("stall.release_flagPC", int'(fpc[1]), 1);
`ifdef FETCH_STALL_CNT_EN
        chk("stall.count", int'(sc[1]), 5);
`endif
        step();

        // halt with branch: halt wins, then resume (held through fetch).
        wait_state(1, 3);
        hl[1] = 1'b1; br[1] = 1'b1;
        @(negedge clock);
        chk("halt.issue_flagPC", int'(fpc[1]), 1);
        step();
        hl[1] = 1'b0; br[1] = 1'b0;
        @(negedge clock);
        chk("halt.state", int'(fs[1]), 6);
        chk("halt.flagPC", int'(fpc[1]), 0);
        step();
        rs[1] = 1'b1;
        @(negedge clock);
        chk("halt.still", int'(fs[1]), 6);
        step();
        @(negedge clock);
        chk("resume.fetch", int'(fs[1]), 1);
        step();
        @(negedge clock);
        chk("resume_ign.wait0", int'(fs[1]), 2);
        step();
        @(negedge clock);
        chk("resume_ign.wait1", int'(fs[1]), 2);
        step();
        @(negedge clock);
        chk("resume_ign.issue", int'(fs[1]), 3);
        step();
        rs[1] = 1'b0;

        // Branch alone after an earlier jr: flagJR must be 0 now.
        wait_state(1, 3);
        br[1] = 1'b1;
        step();
        br[1] = 1'b0;
        @(negedge clock);
        chk("br.sel_state", int'(fs[1]), 4);
        chk("br.sel_flagJR", int'(fjr[1]), 0);
        step();

        // Asynchronous reset in the middle of WAIT.
        wait_state(1, 2);
        #2 reset = 1'b1;
        #1;
        chk("arst.flagPC", int'(fpc[1]), 3);
        chk("arst.inst_valid", int'(iv[1]), 0);
        chk("arst.fetch_state", int'(fs[1]), 0);
        chk("arst.flagJR", int'(fjr[1]), 0);
        chk("arst.other_flagPC", int'(fpc[0]), 3);
        step();
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("arst.idle", int'(fs[1]), 0);
`ifdef FETCH_STALL_CNT_EN
        chk("arst.stall_count", int'(sc[1]), 0);
`endif
        step();
        @(negedge clock);
        chk("arst.restart_fetch", int'(fs[1]), 1);
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
